// File: rtl/execute_md.sv
// Execute stage: operand forwarding, ALU, branch resolution with misprediction
// reporting, and an iterative multiply/divide unit that stalls the pipeline while busy.
module execute_md #(
  parameter int unsigned XLEN      = 32,
  parameter bit          ENABLE_MD = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushE,
  input  logic [1:0]      JumpE,
  input  logic            BranchE,
  input  logic [2:0]      BranchTypeE,
  input  logic [3:0]      ALUControlE,
  input  logic            ALUSrcAE,
  input  logic            ALUSrcBE,
  input  logic            MDValidE,
  input  logic [2:0]      MDOpE,
  input  logic            predict_taken_i,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [1:0]      PCSrcE,
  output logic            StallMDE,
  output logic            branch_mispredict_o,
  output logic            execute_is_branch_o,
  output logic            execute_branch_taken_o,
  output logic [XLEN-1:0] mispredict_target_pc_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam int unsigned ShW  = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} md_state_e;

  md_state_e         state_q;
  logic [XLEN-1:0]   op_a_q, op_b_q, quot_q, rem_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q;
  logic [CntW-1:0]   cnt_q;

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_out, pc_plus4, md_result;
  logic [ShW-1:0]  shamt;

  // Operand selection
  always_comb begin
    case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_a      = ALUSrcAE ? PCE : fwd_a;
  assign src_b      = ALUSrcBE ? ImmExtE : fwd_b;
  assign shamt      = src_b[ShW-1:0];
  assign WriteDataE = fwd_b;
  assign PCTargetE  = PCE + ImmExtE;
  assign pc_plus4   = PCE + XLEN'(4);

  always_comb begin
    case (ALUControlE)
      AluAdd:   alu_out = src_a + src_b;
      AluSub:   alu_out = src_a - src_b;
      AluAnd:   alu_out = src_a & src_b;
      AluOr:    alu_out = src_a | src_b;
      AluXor:   alu_out = src_a ^ src_b;
      AluSlt:   alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      AluSltu:  alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
      AluSll:   alu_out = src_a << shamt;
      AluSrl:   alu_out = src_a >> shamt;
      AluSra:   alu_out = $unsigned($signed(src_a) >>> shamt);
      AluPassB: alu_out = src_b;
      default:  alu_out = '0;
    endcase
  end

  // Branch resolution
  logic cmp_true, is_branch_raw, taken_raw, branch_ok;

  always_comb begin
    case (BranchTypeE)
      3'b000:  cmp_true = (fwd_a == fwd_b);
      3'b001:  cmp_true = (fwd_a != fwd_b);
      3'b100:  cmp_true = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  cmp_true = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  cmp_true = (fwd_a < fwd_b);
      3'b111:  cmp_true = (fwd_a >= fwd_b);
      default: cmp_true = 1'b0;
    endcase
  end

  assign is_branch_raw = BranchE & (JumpE == 2'b00);
  assign taken_raw     = is_branch_raw & cmp_true;
  assign branch_ok     = ~StallMDE & ~FlushE;

  assign execute_is_branch_o    = is_branch_raw & branch_ok;
  assign execute_branch_taken_o = taken_raw & branch_ok;
  assign branch_mispredict_o    = is_branch_raw & branch_ok & (taken_raw != predict_taken_i);
  assign mispredict_target_pc_o = branch_mispredict_o ? (taken_raw ? PCTargetE : pc_plus4) : '0;

  always_comb begin
    if (!branch_ok)                      PCSrcE = 2'b00;
    else if (JumpE == 2'b10)             PCSrcE = 2'b10;
    else if (JumpE == 2'b01 || taken_raw) PCSrcE = 2'b01;
    else                                 PCSrcE = 2'b00;
  end

  // Multiply/divide control
  logic            md_start, op_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, dvsr, q_new, r_new;
  logic [XLEN:0]   shifted, diff;
  logic signed [2*XLEN+1:0] mul_full;
  logic            unused_mul;

  assign md_start = ENABLE_MD & MDValidE & ~FlushE & (state_q == StIdle);
  assign StallMDE = ENABLE_MD & ~FlushE &
                    ((state_q == StIdle & MDValidE) | state_q == StMul | state_q == StDiv);

  assign op_div   = MDOpE[2];
  assign a_signed = op_div ? ~MDOpE[0] : (MDOpE[1:0] == 2'b01 || MDOpE[1:0] == 2'b10);
  assign b_signed = op_div ? ~MDOpE[0] : (MDOpE[1:0] == 2'b01);
  assign a_neg    = a_signed & fwd_a[XLEN-1];
  assign b_neg    = b_signed & fwd_b[XLEN-1];
  assign a_mag    = a_neg ? -fwd_a : fwd_a;
  assign div_zero = (fwd_b == '0);
  assign div_ovf  = ~MDOpE[0] & (fwd_a == MinInt) & (fwd_b == '1);

  // Restoring divide step: the remainder always stays below the divisor
  assign dvsr    = b_neg_q ? -op_b_q : op_b_q;
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign q_new   = {quot_q[XLEN-2:0], ~diff[XLEN]};
  assign r_new   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];

  // Latched sign flags double as the extension bit for the signed product
  assign mul_full = $signed({{(XLEN+1){a_neg_q}}, a_neg_q, op_a_q}) *
                    $signed({{(XLEN+1){b_neg_q}}, b_neg_q, op_b_q});
  assign unused_mul = ^mul_full[2*XLEN+1:2*XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (FlushE) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_start) begin
            op_a_q  <= fwd_a;
            op_b_q  <= fwd_b;
            op_q    <= MDOpE;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            if (!op_div) begin
              state_q <= StMul;
            end else if (div_zero) begin
              quot_q  <= '1;
              rem_q   <= fwd_a;
              state_q <= StDone;
            end else if (div_ovf) begin
              quot_q  <= fwd_a;
              rem_q   <= '0;
              state_q <= StDone;
            end else begin
              quot_q  <= a_mag;
              rem_q   <= '0;
              cnt_q   <= CntW'(XLEN);
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          prod_q  <= mul_full[2*XLEN-1:0];
          state_q <= StDone;
        end
        StDiv: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            quot_q  <= (a_neg_q ^ b_neg_q) ? -q_new : q_new;
            rem_q   <= a_neg_q ? -r_new : r_new;
            state_q <= StDone;
          end else begin
            quot_q <= q_new;
            rem_q  <= r_new;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (op_q)
      3'b000:                md_result = prod_q[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_result = prod_q[2*XLEN-1:XLEN];
      3'b100, 3'b101:        md_result = quot_q;
      default:               md_result = rem_q;
    endcase
    if (!ENABLE_MD) md_result = '0;
  end

  assign ALUResultE = (ENABLE_MD && state_q == StDone) ? md_result : alu_out;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: ALU/forwarding, branch resolution, and the
// multi-cycle multiply/divide stall handshake including flush and reset.
module tb_execute_md;

  logic        clk, rst, FlushE;
  logic [1:0]  JumpE;
  logic        BranchE;
  logic [2:0]  BranchTypeE;
  logic [3:0]  ALUControlE;
  logic        ALUSrcAE, ALUSrcBE, MDValidE;
  logic [2:0]  MDOpE;
  logic        predict_taken_i;
  logic [31:0] RD1E, RD2E, ResultW, ALUResultM, ImmExtE, PCE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE, mispredict_target_pc_o;
  logic [1:0]  PCSrcE;
  logic        StallMDE, branch_mispredict_o, execute_is_branch_o, execute_branch_taken_o;

  int total = 0;
  int bad   = 0;

  execute_md #(.XLEN(32), .ENABLE_MD(1'b1)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .JumpE(JumpE), .BranchE(BranchE),
    .BranchTypeE(BranchTypeE), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
    .ALUSrcBE(ALUSrcBE), .MDValidE(MDValidE), .MDOpE(MDOpE),
    .predict_taken_i(predict_taken_i), .RD1E(RD1E), .RD2E(RD2E), .ResultW(ResultW),
    .ALUResultM(ALUResultM), .ImmExtE(ImmExtE), .PCE(PCE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallMDE(StallMDE),
    .branch_mispredict_o(branch_mispredict_o), .execute_is_branch_o(execute_is_branch_o),
    .execute_branch_taken_o(execute_branch_taken_o),
    .mispredict_target_pc_o(mispredict_target_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    FlushE = 0; JumpE = 0; BranchE = 0; BranchTypeE = 0; ALUControlE = 0;
    ALUSrcAE = 0; ALUSrcBE = 0; MDValidE = 0; MDOpE = 0; predict_taken_i = 0;
    RD1E = 0; RD2E = 0; ResultW = 0; ALUResultM = 0; ImmExtE = 0; PCE = 0;
    ForwardAE = 0; ForwardBE = 0;
  endtask

  // Runs one MD op from its cycle 0 to its DONE cycle; stalls=-1 if it never finishes.
  task automatic md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic [31:0] res);
    bit done = 0;
    MDValidE = 1; MDOpE = op; RD1E = a; RD2E = b;
    ForwardAE = 0; ForwardBE = 0; ALUSrcAE = 0; ALUSrcBE = 0;
    stalls = 0; res = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!StallMDE) begin
        res = ALUResultE; done = 1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      RD1E = $urandom; RD2E = $urandom;
    end
    if (!done) stalls = -1;
    @(posedge clk); #1;
    MDValidE = 0; RD1E = 0; RD2E = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (StallMDE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", StallMDE); end
    total++;
    if ({branch_mispredict_o, execute_is_branch_o, execute_branch_taken_o} !== 3'b000 ||
        mispredict_target_pc_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_branch got=%b%b%b tgt=%h exp=000 tgt=0", branch_mispredict_o,
               execute_is_branch_o, execute_branch_taken_o, mispredict_target_pc_o);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_alu();
    idle_inputs();
    ForwardAE = 2'b10; ALUResultM = 5; RD1E = 99; RD2E = 7; ALUControlE = 4'b0000;
    @(negedge clk);
    total++;
    if (ALUResultE !== 32'd12) begin bad++; $display("FAIL alu_fwd_add got=%h exp=0000000c", ALUResultE); end
    total++;
    if (StallMDE !== 1'b0) begin bad++; $display("FAIL alu_no_stall got=%b exp=0", StallMDE); end
    @(posedge clk); #1;
    ForwardAE = 2'b11; RD1E = 20; ALUSrcBE = 1; ImmExtE = 3; ALUControlE = 4'b0001;
    ForwardBE = 2'b01; ResultW = 32'h55; RD2E = 32'h66;
    @(negedge clk);
    total++;
    if (ALUResultE !== 32'd17) begin bad++; $display("FAIL alu_sub_imm got=%h exp=00000011", ALUResultE); end
    total++;
    if (WriteDataE !== 32'h55) begin bad++; $display("FAIL store_fwd got=%h exp=00000055", WriteDataE); end
    @(posedge clk); #1;
    idle_inputs();
    ALUSrcAE = 1; ALUSrcBE = 1; PCE = 32'h100; ImmExtE = 32'h20; RD1E = 7;
    @(negedge clk);
    total++;
    if (ALUResultE !== 32'h120) begin bad++; $display("FAIL alu_pc_add got=%h exp=00000120", ALUResultE); end
    total++;
    if (PCTargetE !== 32'h120) begin bad++; $display("FAIL pc_target got=%h exp=00000120", PCTargetE); end
    @(posedge clk); #1;
    idle_inputs();
    RD1E = 32'h8000_0000; RD2E = 4; ALUControlE = 4'b1001;
    @(negedge clk);
    total++;
    if (ALUResultE !== 32'hF800_0000) begin bad++; $display("FAIL alu_sra got=%h exp=f8000000", ALUResultE); end
    @(posedge clk); #1;
    RD1E = 1; RD2E = 32'hFFFF_FFFF; ALUControlE = 4'b0110;
    @(negedge clk);
    total++;
    if (ALUResultE !== 32'd1) begin bad++; $display("FAIL alu_sltu got=%h exp=00000001", ALUResultE); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_branch();
    // {is_branch, taken, mispredict}, target, PCSrcE per vector
    logic [2:0]  typ  [8] = '{3'b100, 3'b110, 3'b000, 3'b010, 3'b101, 3'b100, 3'b000, 3'b000};
    logic [31:0] va   [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 5, 32'hFFFF_FFFF, 0, 0};
    logic [31:0] vb   [8] = '{1, 1, 4, 0, 5, 1, 0, 0};
    logic        pred [8] = '{0, 0, 1, 0, 1, 0, 0, 0};
    logic        br   [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0]  jmp  [8] = '{0, 0, 0, 0, 0, 0, 2'b10, 2'b01};
    logic        fl   [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [2:0]  e_st [8] = '{3'b111, 3'b100, 3'b101, 3'b100, 3'b110, 3'b000, 3'b000, 3'b000};
    logic [31:0] e_tg [8] = '{32'h120, 0, 32'h104, 0, 0, 0, 0, 0};
    logic [1:0]  e_ps [8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [2:0]  st;
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      PCE = 32'h100; ImmExtE = 32'h20; BranchTypeE = typ[i]; RD1E = va[i]; RD2E = vb[i];
      predict_taken_i = pred[i]; BranchE = br[i]; JumpE = jmp[i]; FlushE = fl[i];
      @(negedge clk);
      st = {execute_is_branch_o, execute_branch_taken_o, branch_mispredict_o};
      total++;
      if (st !== e_st[i] || mispredict_target_pc_o !== e_tg[i] || PCSrcE !== e_ps[i]) begin
        bad++;
        $display("FAIL branch_vec%0d got st=%b tgt=%h pcsrc=%b exp st=%b tgt=%h pcsrc=%b",
                 i, st, mispredict_target_pc_o, PCSrcE, e_st[i], e_tg[i], e_ps[i]);
      end
      @(posedge clk); #1;
    end
    // Taken-looking branch while the MD unit stalls must report nothing
    idle_inputs();
    BranchE = 1; BranchTypeE = 3'b100; RD1E = 32'hFFFF_FFFF; RD2E = 1; PCE = 32'h100;
    MDValidE = 1; MDOpE = 3'b000;
    @(negedge clk);
    total++;
    if (StallMDE !== 1'b1 || branch_mispredict_o !== 1'b0 || execute_branch_taken_o !== 1'b0 ||
        PCSrcE !== 2'b00) begin
      bad++;
      $display("FAIL branch_during_stall got stall=%b mp=%b tk=%b pcsrc=%b exp 1 0 0 00",
               StallMDE, branch_mispredict_o, execute_branch_taken_o, PCSrcE);
    end
    @(posedge clk); #1;
    FlushE = 1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_mul();
    int stalls;
    logic [31:0] res;
    idle_inputs();
    md_op(3'b001, 32'h8000_0000, 32'h8000_0000, stalls, res);
    total++;
    if (stalls !== 2 || res !== 32'h4000_0000) begin
      bad++; $display("FAIL mulh got stalls=%0d res=%h exp stalls=2 res=40000000", stalls, res);
    end
    md_op(3'b000, 7, 32'hFFFF_FFFD, stalls, res);
    total++;
    if (stalls !== 2 || res !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mul got stalls=%0d res=%h exp stalls=2 res=ffffffeb", stalls, res);
    end
    md_op(3'b010, 32'hFFFF_FFFF, 2, stalls, res);
    total++;
    if (stalls !== 2 || res !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mulhsu got stalls=%0d res=%h exp stalls=2 res=ffffffff", stalls, res);
    end
  endtask

  task automatic test_div();
    int stalls;
    logic [31:0] res;
    idle_inputs();
    md_op(3'b100, 32'hFFFF_FFF9, 2, stalls, res);
    total++;
    if (stalls !== 33 || res !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL div got stalls=%0d res=%h exp stalls=33 res=fffffffd", stalls, res);
    end
    md_op(3'b110, 32'hFFFF_FFF9, 2, stalls, res);
    total++;
    if (stalls !== 33 || res !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL rem got stalls=%0d res=%h exp stalls=33 res=ffffffff", stalls, res);
    end
    md_op(3'b111, 100, 7, stalls, res);
    total++;
    if (stalls !== 33 || res !== 32'd2) begin
      bad++; $display("FAIL remu got stalls=%0d res=%h exp stalls=33 res=00000002", stalls, res);
    end
  endtask

  task automatic test_div_special();
    int stalls;
    logic [31:0] res;
    idle_inputs();
    md_op(3'b101, 123, 0, stalls, res);
    total++;
    if (stalls !== 1 || res !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL divu_zero got stalls=%0d res=%h exp stalls=1 res=ffffffff", stalls, res);
    end
    md_op(3'b110, 32'hFFFF_FFFB, 0, stalls, res);
    total++;
    if (stalls !== 1 || res !== 32'hFFFF_FFFB) begin
      bad++; $display("FAIL rem_zero got stalls=%0d res=%h exp stalls=1 res=fffffffb", stalls, res);
    end
    md_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, stalls, res);
    total++;
    if (stalls !== 1 || res !== 32'h8000_0000) begin
      bad++; $display("FAIL div_ovf got stalls=%0d res=%h exp stalls=1 res=80000000", stalls, res);
    end
    md_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, stalls, res);
    total++;
    if (stalls !== 1 || res !== 32'h0) begin
      bad++; $display("FAIL rem_ovf got stalls=%0d res=%h exp stalls=1 res=00000000", stalls, res);
    end
  endtask

  task automatic test_flush_reset();
    int stalls;
    logic [31:0] res;
    idle_inputs();
    MDValidE = 1; MDOpE = 3'b101; RD1E = 100; RD2E = 7;
    repeat (10) @(posedge clk);
    #1;
    FlushE = 1;
    @(negedge clk);
    total++;
    if (StallMDE !== 1'b0) begin bad++; $display("FAIL flush_stall_drop got=%b exp=0", StallMDE); end
    @(posedge clk); #1;
    FlushE = 0; MDValidE = 0;
    @(negedge clk);
    total++;
    if (StallMDE !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", StallMDE); end
    @(posedge clk); #1;
    md_op(3'b000, 6, 7, stalls, res);
    total++;
    if (stalls !== 2 || res !== 32'd42) begin
      bad++; $display("FAIL mul_after_flush got stalls=%0d res=%h exp stalls=2 res=0000002a", stalls, res);
    end
    MDValidE = 1; MDOpE = 3'b000; RD1E = 3; RD2E = 5;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; MDValidE = 0;
    @(negedge clk);
    total++;
    if (StallMDE !== 1'b0) begin bad++; $display("FAIL reset_mid_mul got=%b exp=0", StallMDE); end
    @(posedge clk); #1;
    md_op(3'b000, 9, 32'hFFFF_FFFE, stalls, res);
    total++;
    if (stalls !== 2 || res !== 32'hFFFF_FFEE) begin
      bad++; $display("FAIL mul_after_reset got stalls=%0d res=%h exp stalls=2 res=ffffffee", stalls, res);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    logic [31:0] res;
    idle_inputs();
    md_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, res);
    total++;
    if (stalls !== 2 || res !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL b2b_mulhu got stalls=%0d res=%h exp stalls=2 res=fffffffe", stalls, res);
    end
    md_op(3'b101, 100, 7, stalls, res);
    total++;
    if (stalls !== 33 || res !== 32'd14) begin
      bad++; $display("FAIL b2b_divu got stalls=%0d res=%h exp stalls=33 res=0000000e", stalls, res);
    end
    RD1E = 1; RD2E = 2; ALUControlE = 4'b0000;
    @(negedge clk);
    total++;
    if (ALUResultE !== 32'd3 || StallMDE !== 1'b0) begin
      bad++; $display("FAIL b2b_alu got res=%h stall=%b exp res=00000003 stall=0", ALUResultE, StallMDE);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_alu();
    test_branch();
    test_mul();
    test_div();
    test_div_special();
    test_flush_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
